hvac_zone_ctrl: RTL and testbench
=================================

HVAC_ZONE_CTRL -- requirements
Module: hvac_zone_ctrl

Interface
REQ-001 SHALL have parameter NZONES, default 4: number of independent zones.
REQ-002 SHALL have parameter TW, default 10: unsigned temperature width, LSB = 0.1 degC.
REQ-003 SHALL have parameter HYST, default 20: start-up hysteresis band, in temperature LSBs.
REQ-004 SHALL have parameter MIN_ON, default 8: minimum run time in clock cycles, valid range >= 1.
REQ-005 SHALL have parameter MIN_OFF, default 8: minimum lockout time in clock cycles, valid range >= 1.
REQ-006 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port en, input, 1 bit: global enable.
REQ-009 SHALL have port target, input, NZONES*TW bits: per-zone setpoint; zone z occupies bits [z*TW +: TW].
REQ-010 SHALL have port ambient, input, NZONES*TW bits: per-zone measured temperature, packed the same way as target.
REQ-011 SHALL have port mode, input, NZONES bits: per-zone mode, 0 = heating, 1 = cooling.
REQ-012 SHALL have port heat, output, NZONES bits: heater drive per zone.
REQ-013 SHALL have port cool, output, NZONES bits: cooler drive per zone.
REQ-014 SHALL have port lg, output, NZONES bits: green lamp per zone, lit when the zone is IDLE.
REQ-015 SHALL have port lr, output, NZONES bits: red lamp per zone, lit when the zone is RUN.
REQ-016 SHALL have port active_cnt, output, $clog2(NZONES+1) bits: number of zones currently in RUN.

Function
REQ-017 Each zone SHALL run an independent FSM with states IDLE, RUN and LOCKOUT, plus a run_mode bit and a cycle counter.
REQ-018 All comparisons SHALL be computed at TW+1 bits so that sums never wrap.
REQ-019 IDLE -> RUN SHALL occur when en=1 and the start condition holds: mode=0 with ambient+HYST <= target, or mode=1 with ambient >= target+HYST.
REQ-020 On IDLE -> RUN, run_mode SHALL latch mode and the counter SHALL clear.
REQ-021 RUN -> LOCKOUT (normal exit) SHALL occur when the counter >= MIN_ON-1 and the stop condition holds: run_mode=0 with ambient >= target, or run_mode=1 with ambient <= target.
REQ-022 RUN -> LOCKOUT SHALL occur immediately, ignoring MIN_ON, when en=0 or when mode != run_mode.
REQ-023 LOCKOUT -> IDLE SHALL occur after exactly MIN_OFF cycles in LOCKOUT, irrespective of en and the temperatures.
REQ-024 The counter SHALL clear on every state entry and saturate at max(MIN_ON, MIN_OFF).
REQ-025 heat[z] SHALL equal (state==RUN and run_mode==0).
REQ-026 cool[z] SHALL equal (state==RUN and run_mode==1).
REQ-027 lg[z] SHALL equal (state==IDLE), and lr[z] SHALL equal (state==RUN).
REQ-028 During LOCKOUT, heat, cool, lg and lr SHALL all be 0.
REQ-029 All outputs SHALL be decoded from registered state only, with no input-to-output combinational path.
REQ-030 Latency: conditions sampled at edge k SHALL produce the state and output change at edge k; outputs are stable until the next edge.
REQ-031 heat[z] and cool[z] SHALL never be 1 simultaneously.
REQ-032 Once a zone enters RUN, its drive output SHALL stay high for at least MIN_ON cycles unless forced off per REQ-022.
REQ-033 The earliest re-entry into RUN SHALL be MIN_OFF+1 edges after LOCKOUT entry.
REQ-034 active_cnt SHALL be the popcount of lr.
REQ-035 Zones SHALL NOT interact: a stimulus on zone z SHALL leave every other zone's state unchanged.

Reset
REQ-036 With rst=0 at a rising edge, every zone SHALL go to IDLE with counter=0 and run_mode=0.
REQ-037 Reset values: heat=0, cool=0, lg=all ones, lr=0, active_cnt=0.
REQ-038 Reset asserted mid-RUN or mid-LOCKOUT SHALL override everything, including the MIN_ON and MIN_OFF guarantees.

Verification (NZONES=4, TW=10, HYST=20, MIN_ON=8, MIN_OFF=8)
REQ-039 Reset: hold rst=0 for 2 cycles with arbitrary inputs -> lg=4'b1111, heat=cool=lr=0, active_cnt=0.
REQ-040 Heat start and hysteresis: zone0 mode=0, target=180, ambient=161 -> stays IDLE; then ambient=160 -> heat[0]=1 at the next edge and active_cnt=1.
REQ-041 Minimum on-time: zone1 mode=1, target=180, ambient=200 -> cool[1]=1; ambient=150 one cycle later -> cool[1] stays 1 for 8 cycles, then LOCKOUT for 8 cycles (all zone1 outputs 0), then lg[1]=1.
REQ-042 Forced exit: zone2 in RUN (heat); mode[2] toggles at cycle 3 -> heat[2]=0 at that edge and LOCKOUT entered; with en=0 on a running zone -> same behaviour.
REQ-043 Width boundary: zone3 mode=0, target=1023, ambient=1003 -> heat[3]=1; mode=1, target=1010, ambient=1023 -> stays IDLE (1023 < 1030 with no wrap).
REQ-044 Independence and reset mid-operation: all 4 zones running with active_cnt=4; rst=0 for 1 cycle -> all zones IDLE next edge and active_cnt=0, with no lockout.

Source files
------------

// File: rtl/hvac_zone_ctrl.sv
// Multi-zone thermostat: each zone runs an IDLE/RUN/LOCKOUT controller with a
// start-up hysteresis band, a minimum run time and a post-run lockout.
module hvac_zone_ctrl #(
   parameter int NZONES  = 4,
   parameter int TW      = 10,
   parameter int HYST    = 20,
   parameter int MIN_ON  = 8,
   parameter int MIN_OFF = 8
) (
   input  logic                        clock,
   input  logic                        rst,
   input  logic                        en,
   input  logic [NZONES*TW-1:0]        target,
   input  logic [NZONES*TW-1:0]        ambient,
   input  logic [NZONES-1:0]           mode,
   output logic [NZONES-1:0]           heat,
   output logic [NZONES-1:0]           cool,
   output logic [NZONES-1:0]           lg,
   output logic [NZONES-1:0]           lr,
   output logic [$clog2(NZONES+1)-1:0] active_cnt
);

   localparam int CMAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int AW   = $clog2(NZONES + 1);

   localparam logic [CW-1:0] CNT_MAX  = CW'(CMAX);
   localparam logic [CW-1:0] ON_LAST  = CW'(MIN_ON - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(MIN_OFF - 1);
   localparam logic [TW:0]   HYST_X   = (TW+1)'(HYST);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   genvar gi;
   generate
      for (gi = 0; gi < NZONES; gi++) begin : g_zone
         logic [TW:0]   tgt_x;
         logic [TW:0]   amb_x;
         logic          start_ok;
         logic          stop_ok;
         logic          force_off;
         state_t        state_q;
         state_t        state_d;
         logic          run_mode_q;
         logic          run_mode_d;
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;
         logic          heat_q;
         logic          cool_q;
         logic          lg_q;
         logic          lr_q;

         // One extra bit keeps temperature-plus-band sums from wrapping.
         assign tgt_x = {1'b0, target[gi*TW +: TW]};
         assign amb_x = {1'b0, ambient[gi*TW +: TW]};

         assign start_ok  = mode[gi] ? (amb_x >= tgt_x + HYST_X)
                                     : (amb_x + HYST_X <= tgt_x);
         assign stop_ok   = run_mode_q ? (amb_x <= tgt_x) : (amb_x >= tgt_x);
         assign force_off = !en || (mode[gi] != run_mode_q);

         always_comb begin
            state_d    = state_q;
            run_mode_d = run_mode_q;
            cnt_d      = (cnt_q < CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
            case (state_q)
               ST_IDLE: begin
                  if (en && start_ok) begin
                     state_d    = ST_RUN;
                     run_mode_d = mode[gi];
                     cnt_d      = '0;
                  end
               end
               ST_RUN: begin
                  if (force_off || ((cnt_q >= ON_LAST) && stop_ok)) begin
                     state_d = ST_LOCK;
                     cnt_d   = '0;
                  end
               end
               ST_LOCK: begin
                  if (cnt_q >= OFF_LAST) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end

         // Outputs are registered from the next state so they change on the
         // same edge as the state itself.
         always_ff @(posedge clock) begin
            if (!rst) begin
               state_q    <= ST_IDLE;
               run_mode_q <= 1'b0;
               cnt_q      <= '0;
               heat_q     <= 1'b0;
               cool_q     <= 1'b0;
               lg_q       <= 1'b1;
               lr_q       <= 1'b0;
            end else begin
               state_q    <= state_d;
               run_mode_q <= run_mode_d;
               cnt_q      <= cnt_d;
               heat_q     <= (state_d == ST_RUN) && !run_mode_d;
               cool_q     <= (state_d == ST_RUN) && run_mode_d;
               lg_q       <= (state_d == ST_IDLE);
               lr_q       <= (state_d == ST_RUN);
            end
         end

         assign heat[gi] = heat_q;
         assign cool[gi] = cool_q;
         assign lg[gi]   = lg_q;
         assign lr[gi]   = lr_q;
      end
   endgenerate

   always_comb begin
      active_cnt = '0;
      for (int i = 0; i < NZONES; i++) begin
         active_cnt = active_cnt + AW'(lr[i]);
      end
   end

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Bench for hvac_zone_ctrl: timestamp-based zone model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hvac_zone_ctrl;

   localparam int NZ      = 4;
   localparam int TW      = 10;
   localparam int HYST    = 20;
   localparam int MIN_ON  = 8;
   localparam int MIN_OFF = 8;
   localparam int AW      = $clog2(NZ + 1);

   logic             clock;
   logic             rst;
   logic             en;
   logic [NZ*TW-1:0] target;
   logic [NZ*TW-1:0] ambient;
   logic [NZ-1:0]    mode;
   logic [NZ-1:0]    heat;
   logic [NZ-1:0]    cool;
   logic [NZ-1:0]    lg;
   logic [NZ-1:0]    lr;
   logic [AW-1:0]    active_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: edge index at which a zone entered RUN / LOCKOUT, -1 if not there.
   int k_edge = 0;
   int m_run_at [NZ];
   int m_lock_at[NZ];
   bit m_dir    [NZ];

   hvac_zone_ctrl #(
      .NZONES (NZ),
      .TW     (TW),
      .HYST   (HYST),
      .MIN_ON (MIN_ON),
      .MIN_OFF(MIN_OFF)
   ) dut (
      .clock     (clock),
      .rst       (rst),
      .en        (en),
      .target    (target),
      .ambient   (ambient),
      .mode      (mode),
      .heat      (heat),
      .cool      (cool),
      .lg        (lg),
      .lr        (lr),
      .active_cnt(active_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_zone(input int z, input bit md, input int t, input int a);
      mode[z]             = md;
      target[z*TW +: TW]  = t[TW-1:0];
      ambient[z*TW +: TW] = a[TW-1:0];
   endtask

   task automatic model_step();
      k_edge++;
      for (int z = 0; z < NZ; z++) begin
         int t;
         int a;
         bit md;
         t  = int'(target[z*TW +: TW]);
         a  = int'(ambient[z*TW +: TW]);
         md = mode[z];
         if (!rst) begin
            m_run_at[z]  = -1;
            m_lock_at[z] = -1;
            m_dir[z]     = 1'b0;
         end else if (m_run_at[z] >= 0) begin
            if (!en || md != m_dir[z] ||
                ((k_edge - m_run_at[z] >= MIN_ON) && (m_dir[z] ? (a <= t) : (a >= t)))) begin
               m_run_at[z]  = -1;
               m_lock_at[z] = k_edge;
            end
         end else if (m_lock_at[z] >= 0) begin
            if (k_edge - m_lock_at[z] >= MIN_OFF) m_lock_at[z] = -1;
         end else if (en && (md ? (a >= t + HYST) : (a + HYST <= t))) begin
            m_run_at[z] = k_edge;
            m_dir[z]    = md;
         end
      end
   endtask

   initial begin
      for (int z = 0; z < NZ; z++) begin
         m_run_at[z]  = -1;
         m_lock_at[z] = -1;
         m_dir[z]     = 1'b0;
      end
      forever begin
         @(posedge clock);
         model_step();
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      logic [NZ-1:0] eh, ec, elg, elr;
      int ecnt;
      @(posedge clock);
      forever begin
         @(negedge clock);
         eh = '0; ec = '0; elg = '0; elr = '0; ecnt = 0;
         for (int z = 0; z < NZ; z++) begin
            if (m_run_at[z] >= 0) begin
               elr[z] = 1'b1;
               ecnt++;
               if (m_dir[z]) ec[z] = 1'b1;
               else          eh[z] = 1'b1;
            end else if (m_lock_at[z] < 0) begin
               elg[z] = 1'b1;
            end
         end
         check("model_heat", heat, eh);
         check("model_cool", cool, ec);
         check("model_lg", lg, elg);
         check("model_lr", lr, elr);
         check("model_active_cnt", active_cnt, ecnt);
      end
   end

   initial begin
      // Reset held with inputs that would otherwise start every zone.
      rst = 1'b0;
      en  = 1'b1;
      for (int z = 0; z < NZ; z++) set_zone(z, 1'b0, 500, 100);
      tick(2);
      check("rst_lg", lg, 4'b1111);
      check("rst_heat", heat, 0);
      check("rst_cool", cool, 0);
      check("rst_lr", lr, 0);
      check("rst_active_cnt", active_cnt, 0);
      for (int z = 0; z < NZ; z++) set_zone(z, 1'b0, 0, 500);
      rst = 1'b1;

      // Heating hysteresis edge.
      set_zone(0, 1'b0, 180, 161);
      tick(3);
      check("hyst_161_idle_heat0", heat[0], 0);
      check("hyst_161_idle_lg0", lg[0], 1);
      set_zone(0, 1'b0, 180, 160);
      tick(1);
      check("hyst_160_heat0", heat[0], 1);
      check("hyst_160_active_cnt", active_cnt, 1);
      set_zone(0, 1'b0, 0, 500);
      tick(17);

      // Minimum on-time then lockout on a cooling zone.
      set_zone(1, 1'b1, 180, 200);
      tick(1);
      check("cool1_start", cool[1], 1);
      set_zone(1, 1'b1, 180, 150);
      for (int i = 0; i < MIN_ON; i++) begin
         check("min_on_cool1", cool[1], 1);
         tick(1);
      end
      for (int i = 0; i < MIN_OFF; i++) begin
         check("lockout_z1_outputs", {heat[1], cool[1], lg[1], lr[1]}, 0);
         tick(1);
      end
      check("z1_back_idle_lg", lg[1], 1);
      set_zone(1, 1'b0, 0, 500);

      // Forced exit by mode change, earliest re-entry, forced exit by en=0.
      set_zone(2, 1'b0, 200, 100);
      tick(1);
      check("z2_heat_start", heat[2], 1);
      tick(2);
      mode[2] = 1'b1;
      tick(1);
      check("z2_mode_flip_lockout", {heat[2], cool[2], lg[2], lr[2]}, 0);
      mode[2] = 1'b0;
      tick(8);
      check("z2_reentry_not_yet", heat[2], 0);
      check("z2_idle_after_lockout", lg[2], 1);
      tick(1);
      check("z2_reentry_heat", heat[2], 1);
      en = 1'b0;
      tick(1);
      check("z2_en_off_heat", heat[2], 0);
      check("z2_en_off_lr", lr[2], 0);
      en = 1'b1;
      set_zone(2, 1'b0, 0, 500);
      tick(10);

      // Width boundary at the top of the temperature range.
      set_zone(3, 1'b0, 1023, 1003);
      tick(1);
      check("z3_heat_1023", heat[3], 1);
      set_zone(3, 1'b0, 0, 500);
      tick(18);
      set_zone(3, 1'b1, 1010, 1023);
      tick(3);
      check("z3_cool_nowrap_lg", lg[3], 1);
      check("z3_cool_nowrap_cool", cool[3], 0);
      set_zone(3, 1'b0, 0, 500);
      tick(2);

      // All zones running, then a one-cycle reset bypasses lockout.
      set_zone(0, 1'b0, 300, 100);
      set_zone(1, 1'b1, 100, 300);
      set_zone(2, 1'b0, 300, 100);
      set_zone(3, 1'b1, 100, 300);
      tick(1);
      check("all_run_active_cnt", active_cnt, 4);
      check("all_run_lr", lr, 4'b1111);
      rst = 1'b0;
      tick(1);
      check("midrun_rst_lg", lg, 4'b1111);
      check("midrun_rst_active_cnt", active_cnt, 0);
      check("midrun_rst_drives", {heat, cool}, 0);
      rst = 1'b1;
      tick(1);
      check("restart_active_cnt", active_cnt, 4);
      check("restart_heat", heat, 4'b0101);
      check("restart_cool", cool, 4'b1010);
      tick(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
